// File: rtl/button_debounce_if.sv
// Push-button debounce signal bundle: raw level in, qualified level and status out.
interface button_debounce_if;
    logic button_in;
    logic button_out;
    logic changing;

    // Board/stimulus side: drives the raw button, observes the debounced result.
    modport master (
        output button_in,
        input  button_out,
        input  changing
    );

    // Debouncer side.
    modport slave (
        input  button_in,
        output button_out,
        output changing
    );
endinterface

// File: rtl/button_debounce.sv
// Push-button debouncer: two-flop synchronizer followed by a four-state
// qualify FSM. A new level is accepted only after DEBOUNCE_CNT+1 consecutive
// synchronized samples; any interruption restarts qualification.
// Legal configuration: 1 <= DEBOUNCE_CNT <= 2**CNT_WIDTH-1.
module button_debounce #(
    parameter int unsigned CNT_WIDTH    = 20,
    parameter int unsigned DEBOUNCE_CNT = 500000
) (
    input  logic              clk,
    input  logic              reset,
    button_debounce_if.slave  btn
);

    // Terminal count: the WAIT state qualifies when the counter reaches this value.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } state_t;

    logic                 sync1;
    logic                 sync_q;
    state_t               state;
    state_t               next_state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] next_cnt;
    logic                 button_out_q;
    logic                 changing_q;
    logic                 next_button_out;
    logic                 next_changing;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sync1  <= btn.button_in;
            sync_q <= sync1;
        end
    end

    // State, counter and registered Moore outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE_LOW;
            cnt          <= '0;
            button_out_q <= 1'b0;
            changing_q   <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= next_cnt;
            button_out_q <= next_button_out;
            changing_q   <= next_changing;
        end
    end

    // Next-state and counter logic; outputs are decoded from the next state so
    // the registered copies track the state register exactly.
    always_comb begin
        next_state      = state;
        next_cnt        = cnt;
        next_button_out = 1'b0;
        next_changing   = 1'b0;

        case (state)
            IDLE_LOW: begin
                if (sync_q) begin
                    next_state = WAIT_HIGH;
                    next_cnt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_q) begin
                    next_state = IDLE_LOW;
                    next_cnt   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE_HIGH;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_WIDTH'(1);
                end
            end
            IDLE_HIGH: begin
                if (!sync_q) begin
                    next_state = WAIT_LOW;
                    next_cnt   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_q) begin
                    next_state = IDLE_HIGH;
                    next_cnt   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE_LOW;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                next_state = IDLE_LOW;
                next_cnt   = '0;
            end
        endcase

        next_button_out = (next_state == IDLE_HIGH) || (next_state == WAIT_LOW);
        next_changing   = (next_state == WAIT_HIGH) || (next_state == WAIT_LOW);
    end

    assign btn.button_out = button_out_q;
    assign btn.changing   = changing_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with DEBOUNCE_CNT=4, CNT_WIDTH=3.
// Stimulus pushes expected output transitions (value and cycle); a negedge
// monitor pops and compares each transition it observes on the DUT outputs.
module tb_button_debounce;

    localparam int unsigned CNT_WIDTH    = 3;
    localparam int unsigned DEBOUNCE_CNT = 4;
    localparam int          LAT          = DEBOUNCE_CNT + 3;

    typedef struct {
        int   cyc;
        logic val;
    } ev_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   exp_rises;
    int   pulses;

    ev_t  out_q[$];
    ev_t  chg_q[$];

    button_debounce_if bif ();

    button_debounce #(
        .CNT_WIDTH    (CNT_WIDTH),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every observed transition must match the head of its queue.
    logic prev_out;
    logic prev_chg;
    logic out_d;
    int   last_out_cyc;
    initial begin
        prev_out     = 1'b0;
        prev_chg     = 1'b0;
        out_d        = 1'b0;
        last_out_cyc = -100;
    end

    always @(negedge clk) begin
        ev_t e;
        if (bif.button_out !== prev_out) begin
            checks++;
            if (out_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: cyc=%0d actual=%b required=no change", cyc, bif.button_out);
            end else begin
                e = out_q.pop_front();
                if (e.val !== bif.button_out || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL out_event: actual val=%b cyc=%0d required val=%b cyc=%0d",
                             bif.button_out, cyc, e.val, e.cyc);
                end
            end
            checks++;
            if (cyc - last_out_cyc < int'(DEBOUNCE_CNT) + 1) begin
                errors++;
                $display("FAIL out_spacing: actual gap=%0d required>=%0d", cyc - last_out_cyc, DEBOUNCE_CNT + 1);
            end
            last_out_cyc = cyc;
            prev_out     = bif.button_out;
        end
        if (bif.changing !== prev_chg) begin
            checks++;
            if (chg_q.size() == 0) begin
                errors++;
                $display("FAIL chg_unexpected: cyc=%0d actual=%b required=no change", cyc, bif.changing);
            end else begin
                e = chg_q.pop_front();
                if (e.val !== bif.changing || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL chg_event: actual val=%b cyc=%0d required val=%b cyc=%0d",
                             bif.changing, cyc, e.val, e.cyc);
                end
            end
            prev_chg = bif.changing;
        end
        // Downstream rising-edge pulse generator model.
        if (bif.button_out && !out_d) pulses++;
        out_d = bif.button_out;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_out(input int c, input logic v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        out_q.push_back(e);
        if (v) exp_rises++;
    endtask

    task automatic push_chg(input int c, input logic v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        chg_q.push_back(e);
    endtask

    // Drive a new held level and expect a full qualification.
    task automatic qualify(input logic v);
        int k;
        k = cyc;
        push_chg(k + 3, 1'b1);
        push_chg(k + LAT, 1'b0);
        push_out(k + LAT, v);
        bif.button_in = v;
    endtask

    task automatic check_outs(input string name, input logic exp_out, input logic exp_chg);
        checks++;
        if (bif.button_out !== exp_out || bif.changing !== exp_chg) begin
            errors++;
            $display("FAIL %s: actual out=%b chg=%b required out=%b chg=%b",
                     name, bif.button_out, bif.changing, exp_out, exp_chg);
        end
    endtask

    initial begin
        int k;
        checks        = 0;
        errors        = 0;
        exp_rises     = 0;
        pulses        = 0;
        reset         = 1'b1;
        bif.button_in = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check_outs("reset_state", 1'b0, 1'b0);
        reset = 1'b0;
        idle(3);
        check_outs("post_reset_idle", 1'b0, 1'b0);

        // Clean press, then clean release.
        qualify(1'b1);
        idle(12);
        check_outs("press_held", 1'b1, 1'b0);
        qualify(1'b0);
        idle(12);
        check_outs("release_held", 1'b0, 1'b0);

        // High glitch of exactly DEBOUNCE_CNT cycles: one sample short.
        k = cyc;
        push_chg(k + 3, 1'b1);
        push_chg(k + 7, 1'b0);
        bif.button_in = 1'b1;
        idle(4);
        bif.button_in = 1'b0;
        idle(12);
        check_outs("glitch_high", 1'b0, 1'b0);

        // Bounce 1,0,1,1,0 then hold 1.
        k = cyc;
        push_chg(k + 3, 1'b1);
        push_chg(k + 4, 1'b0);
        push_chg(k + 5, 1'b1);
        push_chg(k + 7, 1'b0);
        push_chg(k + 8, 1'b1);
        push_chg(k + 12, 1'b0);
        push_out(k + 12, 1'b1);
        bif.button_in = 1'b1; idle(1);
        bif.button_in = 1'b0; idle(1);
        bif.button_in = 1'b1; idle(1);
        bif.button_in = 1'b1; idle(1);
        bif.button_in = 1'b0; idle(1);
        bif.button_in = 1'b1;
        idle(14);
        check_outs("bounce_press", 1'b1, 1'b0);

        // Low glitch while high: output stays 1.
        k = cyc;
        push_chg(k + 3, 1'b1);
        push_chg(k + 7, 1'b0);
        bif.button_in = 1'b0;
        idle(4);
        bif.button_in = 1'b1;
        idle(12);
        check_outs("glitch_low", 1'b1, 1'b0);

        qualify(1'b0);
        idle(12);

        // Reset pulse in WAIT_HIGH with counter=2, button held.
        k = cyc;
        push_chg(k + 3, 1'b1);
        bif.button_in = 1'b1;
        idle(5);
        check_outs("wait_high_before_reset", 1'b0, 1'b1);
        push_chg(k + 5, 1'b0);
        push_chg(k + 8, 1'b1);
        push_chg(k + 12, 1'b0);
        push_out(k + 12, 1'b1);
        reset = 1'b1;
        #1;
        check_outs("reset_async_wait", 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        idle(12);
        check_outs("requalified_after_reset", 1'b1, 1'b0);

        // Reset pulse in IDLE_HIGH, button held.
        k = cyc;
        push_out(k, 1'b0);
        push_chg(k + 3, 1'b1);
        push_chg(k + 7, 1'b0);
        push_out(k + 7, 1'b1);
        reset = 1'b1;
        #1;
        check_outs("reset_async_high", 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        idle(12);

        qualify(1'b0);
        idle(12);
        check_outs("final_idle", 1'b0, 1'b0);

        // Drain: any expected transition still queued was never observed.
        for (int i = 0; i < 50 && (out_q.size() != 0 || chg_q.size() != 0); i++) @(posedge clk);
        while (out_q.size() != 0) begin
            ev_t e;
            e = out_q.pop_front();
            checks++;
            errors++;
            $display("FAIL out_missing: actual=none required val=%b cyc=%0d", e.val, e.cyc);
        end
        while (chg_q.size() != 0) begin
            ev_t e;
            e = chg_q.pop_front();
            checks++;
            errors++;
            $display("FAIL chg_missing: actual=none required val=%b cyc=%0d", e.val, e.cyc);
        end

        checks++;
        if (pulses != exp_rises) begin
            errors++;
            $display("FAIL chain_pulses: actual=%0d required=%0d", pulses, exp_rises);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
